// File: rtl/pong_match_sequencer_if.sv
// Bundle of the match sequencer's non-clock signals.
// Inputs to the sequencer: frame tick, UART key byte stream, score pulses
// from the ball engine. Outputs: ball/paddle gating, serve direction,
// both scores, winner and the raw state code for debug LEDs.
// slave  : the sequencer side.
// master : the driving side (game top level or testbench).
interface pong_match_sequencer_if;
  logic       i_frame_tick;
  logic       i_key_valid;
  logic [7:0] i_key_byte;
  logic       i_p1_scored;
  logic       i_p2_scored;
  logic       o_ball_rst;
  logic       o_ball_en;
  logic       o_paddle_en;
  logic       o_serve_dir;
  logic [3:0] o_p1_score;
  logic [3:0] o_p2_score;
  logic [1:0] o_winner;
  logic [2:0] o_state;

  modport slave (
    input  i_frame_tick, i_key_valid, i_key_byte, i_p1_scored, i_p2_scored,
    output o_ball_rst, o_ball_en, o_paddle_en, o_serve_dir,
           o_p1_score, o_p2_score, o_winner, o_state
  );

  modport master (
    output i_frame_tick, i_key_valid, i_key_byte, i_p1_scored, i_p2_scored,
    input  o_ball_rst, o_ball_en, o_paddle_en, o_serve_dir,
           o_p1_score, o_p2_score, o_winner, o_state
  );
endinterface

// File: rtl/pong_match_sequencer.sv
// Match-level controller for Pong: sequences IDLE -> SERVE -> PLAY ->
// POINT (-> PAUSE / OVER), keeps both scores and gates ball/paddle motion.
// Ports:
//   i_CLK   : system pixel clock
//   i_RST_n : synchronous reset, active low
//   bus     : pong_match_sequencer_if.slave (key stream, frame tick,
//             score pulses in; gating, scores, winner, state out)
// All outputs are registered and decoded from the next state, so they
// change in the same cycle as the state register.
module pong_match_sequencer #(
  parameter logic [7:0] START_KEY   = 8'd32,
  parameter logic [7:0] PAUSE_KEY   = 8'd112,
  parameter int         SERVE_TICKS = 60,
  parameter int         POINT_TICKS = 30,
  parameter int         WIN_SCORE   = 7
) (
  input logic                   i_CLK,
  input logic                   i_RST_n,
  pong_match_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_PAUSE = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS);
  localparam logic [7:0] POINT_LAST = 8'(POINT_TICKS);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

  // Scores stop at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  function automatic logic dec_ball_rst(input state_t s);
    return (s == ST_IDLE) || (s == ST_SERVE) || (s == ST_OVER);
  endfunction

  function automatic logic dec_paddle_en(input state_t s);
    return (s == ST_SERVE) || (s == ST_PLAY);
  endfunction

  state_t     state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [3:0] p1_r, p1_nxt_s, p2_r, p2_nxt_s;
  logic [1:0] winner_r, winner_nxt_s;
  logic       dir_r, dir_nxt_s;
  logic       ball_rst_r, ball_en_r, paddle_en_r;
  logic       start_s, pause_s;

  assign start_s   = bus.i_key_valid && (bus.i_key_byte == START_KEY);
  assign pause_s   = bus.i_key_valid && (bus.i_key_byte == PAUSE_KEY);
  assign cnt_inc_s = cnt_r + 8'd1;

  // Next-state and datapath update for the match FSM.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    p1_nxt_s     = p1_r;
    p2_nxt_s     = p2_r;
    winner_nxt_s = winner_r;
    dir_nxt_s    = dir_r;
    case (state_r)
      ST_IDLE: begin
        // Scores/winner survive here so the last result stays on display.
        if (start_s) begin
          state_nxt_s = ST_SERVE;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (bus.i_frame_tick) begin
          if (cnt_inc_s == SERVE_LAST) begin
            state_nxt_s = ST_PLAY;
            cnt_nxt_s   = 8'd0;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_PLAY: begin
        // Player 1 wins a simultaneous score; any score beats a pause key.
        // The loser of the point receives the next serve.
        if (bus.i_p1_scored) begin
          p1_nxt_s    = sat_inc(p1_r);
          dir_nxt_s   = 1'b1;
          state_nxt_s = ST_POINT;
          cnt_nxt_s   = 8'd0;
        end else if (bus.i_p2_scored) begin
          p2_nxt_s    = sat_inc(p2_r);
          dir_nxt_s   = 1'b0;
          state_nxt_s = ST_POINT;
          cnt_nxt_s   = 8'd0;
        end else if (pause_s) begin
          state_nxt_s = ST_PAUSE;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_POINT: begin
        if (bus.i_frame_tick) begin
          if (cnt_inc_s == POINT_LAST) begin
            cnt_nxt_s = 8'd0;
            if (p1_r == WIN_VAL) begin
              state_nxt_s  = ST_OVER;
              winner_nxt_s = 2'b01;
            end else if (p2_r == WIN_VAL) begin
              state_nxt_s  = ST_OVER;
              winner_nxt_s = 2'b10;
            end else begin
              state_nxt_s = ST_SERVE;
            end
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_PAUSE: begin
        if (pause_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (start_s) begin
          state_nxt_s  = ST_SERVE;
          cnt_nxt_s    = 8'd0;
          p1_nxt_s     = 4'd0;
          p2_nxt_s     = 4'd0;
          winner_nxt_s = 2'b00;
          dir_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      default: begin
        // Illegal encodings recover to IDLE.
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, datapath and output registers; reset overrides every event.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      p1_r        <= 4'd0;
      p2_r        <= 4'd0;
      winner_r    <= 2'b00;
      dir_r       <= 1'b0;
      ball_rst_r  <= 1'b1;
      ball_en_r   <= 1'b0;
      paddle_en_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      p1_r        <= p1_nxt_s;
      p2_r        <= p2_nxt_s;
      winner_r    <= winner_nxt_s;
      dir_r       <= dir_nxt_s;
      ball_rst_r  <= dec_ball_rst(state_nxt_s);
      ball_en_r   <= (state_nxt_s == ST_PLAY);
      paddle_en_r <= dec_paddle_en(state_nxt_s);
    end
  end

  assign bus.o_ball_rst  = ball_rst_r;
  assign bus.o_ball_en   = ball_en_r;
  assign bus.o_paddle_en = paddle_en_r;
  assign bus.o_serve_dir = dir_r;
  assign bus.o_p1_score  = p1_r;
  assign bus.o_p2_score  = p2_r;
  assign bus.o_winner    = winner_r;
  assign bus.o_state     = state_r;

endmodule
